// File: rtl/clock_enable_multi.sv
// Multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick and a toggling square wave.
module clock_enable_multi #(
  parameter int CNT_W       = 17,
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              run,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [CNT_W-1:0]  eff   [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] wr_hit, tc;

  always_comb begin
    wr_hit = '0;
    tc     = '0;
    pend_d = pend_q;
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      act_d[i] = act_q[i];
      shd_d[i] = shd_q[i];
      // Out-of-range selects match no channel, so the write is dropped.
      wr_hit[i] = div_wr && (div_sel == SEL_W'(i));
      eff[i] = (act_q[i] == '0) ? ONE : act_q[i];
      tc[i] = run && !sync && (cnt_q[i] == eff[i] - ONE);
      if (sync || tc[i]) begin
        cnt_d[i]  = '0;
        act_d[i]  = wr_hit[i] ? div_data : shd_q[i];
        shd_d[i]  = wr_hit[i] ? div_data : shd_q[i];
        pend_d[i] = 1'b0;
        tick_d[i] = tc[i];
        sq_d[i]   = sync ? 1'b0 : ~sq_q[i];
      end else begin
        if (run) begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
        if (wr_hit[i]) begin
          shd_d[i]  = div_data;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV;
        shd_q[i] <= DEF_DIV;
      end
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign div_pending = pend_q;
  assign tick        = tick_q;
  assign sq          = sq_q;

endmodule

// File: tb/tb_clock_enable_multi.sv
// Directed bench for clock_enable_multi.
// Config: CNT_W=8, NUM_CH=4, SEL_W=3, DEFAULT_DIV=5.
module tb_clock_enable_multi;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              run;
  logic              sync;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] div_pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  clock_enable_multi #(
    .CNT_W(CNT_W),
    .NUM_CH(NUM_CH),
    .SEL_W(SEL_W),
    .DEFAULT_DIV(5)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .run(run),
    .sync(sync),
    .div_wr(div_wr),
    .div_sel(div_sel),
    .div_data(div_data),
    .div_pending(div_pending),
    .tick(tick),
    .sq(sq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    run = 1'b0;
    sync = 1'b0;
    div_wr = 1'b0;
    div_sel = '0;
    div_data = '0;
    cyc();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    run = 1'b1;
    sync = 1'b0;
    div_wr = 1'b1;
    div_sel = 3'd1;
    div_data = 8'd9;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      nvec++;
      if ({div_pending, tick, sq} !== 12'h000) begin
        nerr++;
        $display("FAIL reset j=%0d pend=%b tick=%b sq=%b exp all 0",
                 j, div_pending, tick, sq);
      end
    end
    div_wr = 1'b0;
    run = 1'b0;
    clr_n = 1'b1;
  endtask

  task automatic test_count();
    logic [3:0] et, es;
    do_reset();
    run = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      et = (j % 5 == 0) ? 4'hF : 4'h0;
      es = ((j / 5) % 2 == 1) ? 4'hF : 4'h0;
      nvec++;
      if (tick !== et || sq !== es || div_pending !== 4'h0) begin
        nerr++;
        $display("FAIL count j=%0d tick=%b sq=%b pend=%b exp %b %b 0000",
                 j, tick, sq, div_pending, et, es);
      end
    end
  endtask

  task automatic test_div_write();
    logic [3:0] et, es;
    logic t5, t3;
    do_reset();
    run = 1'b1;
    cyc();
    cyc();
    div_wr = 1'b1;
    div_sel = 3'd2;
    div_data = 8'd7;
    cyc();
    div_data = 8'd3;
    cyc();
    nvec++;
    if (div_pending !== 4'b0100 || tick !== 4'h0) begin
      nerr++;
      $display("FAIL wr_pend pend=%b tick=%b exp 0100 0000",
               div_pending, tick);
    end
    div_wr = 1'b0;
    cyc();
    nvec++;
    if (div_pending !== 4'b0000 || tick !== 4'hF || sq !== 4'hF) begin
      nerr++;
      $display("FAIL wr_apply pend=%b tick=%b sq=%b exp 0000 1111 1111",
               div_pending, tick, sq);
    end
    for (int t = 1; t <= 10; t++) begin
      cyc();
      t5 = (t % 5 == 0);
      t3 = (t % 3 == 0);
      et = {t5, t3, t5, t5};
      t5 = ((t / 5) % 2 == 0);
      t3 = ((t / 3) % 2 == 0);
      es = {t5, t3, t5, t5};
      nvec++;
      if (tick !== et || sq !== es || div_pending !== 4'h0) begin
        nerr++;
        $display("FAIL wr_period t=%0d tick=%b sq=%b exp %b %b",
                 t, tick, sq, et, es);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    run = 1'b1;
    for (int j = 1; j <= 7; j++) cyc();
    run = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      cyc();
      nvec++;
      if (tick !== 4'h0 || sq !== 4'hF) begin
        nerr++;
        $display("FAIL pause j=%0d tick=%b sq=%b exp 0000 1111",
                 j, tick, sq);
      end
    end
    run = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      nvec++;
      if (tick !== ((j == 3) ? 4'hF : 4'h0) ||
          sq !== ((j == 3) ? 4'h0 : 4'hF)) begin
        nerr++;
        $display("FAIL resume j=%0d tick=%b sq=%b", j, tick, sq);
      end
    end
  endtask

  task automatic test_sync();
    logic [3:0] et;
    logic t5;
    do_reset();
    run = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      div_wr = (j == 6);
      div_sel = 3'd0;
      div_data = 8'd4;
      cyc();
    end
    div_wr = 1'b0;
    nvec++;
    if (div_pending !== 4'b0001 || sq !== 4'hF) begin
      nerr++;
      $display("FAIL sync_pre pend=%b sq=%b exp 0001 1111",
               div_pending, sq);
    end
    sync = 1'b1;
    div_wr = 1'b1;
    div_sel = 3'd3;
    div_data = 8'd2;
    cyc();
    sync = 1'b0;
    div_wr = 1'b0;
    nvec++;
    if (div_pending !== 4'h0 || tick !== 4'h0 || sq !== 4'h0) begin
      nerr++;
      $display("FAIL sync pend=%b tick=%b sq=%b exp all 0",
               div_pending, tick, sq);
    end
    for (int j = 1; j <= 8; j++) begin
      cyc();
      t5 = (j % 5 == 0);
      et = {(j % 2 == 0), t5, t5, (j % 4 == 0)};
      nvec++;
      if (tick !== et || div_pending !== 4'h0) begin
        nerr++;
        $display("FAIL sync_run j=%0d tick=%b pend=%b exp %b 0000",
                 j, tick, div_pending, et);
      end
    end
  endtask

  task automatic test_wr_at_tc();
    logic [3:0] et;
    do_reset();
    run = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      div_wr = (j == 5);
      div_sel = 3'd0;
      div_data = 8'd2;
      cyc();
      if (j >= 5) begin
        et = {3'b000, (j % 2 == 1)};
        if (j == 5 || j == 10) et[3:1] = 3'b111;
        nvec++;
        if (tick !== et || div_pending !== 4'h0) begin
          nerr++;
          $display("FAIL wr_tc j=%0d tick=%b pend=%b exp %b 0000",
                   j, tick, div_pending, et);
        end
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_zero_div();
    logic [3:0] et, es;
    logic t5, s5;
    do_reset();
    div_wr = 1'b1;
    div_sel = 3'd1;
    div_data = 8'd0;
    cyc();
    div_sel = 3'd7;
    div_data = 8'd9;
    cyc();
    div_wr = 1'b0;
    nvec++;
    if (div_pending !== 4'b0010 || tick !== 4'h0 || sq !== 4'h0) begin
      nerr++;
      $display("FAIL sel7 pend=%b tick=%b sq=%b exp 0010 0000 0000",
               div_pending, tick, sq);
    end
    run = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      cyc();
      t5 = (j % 5 == 0);
      s5 = ((j / 5) % 2 == 1);
      et = {t5, t5, (j >= 5), t5};
      es = {s5, s5, (j >= 5) && ((j - 4) % 2 == 1), s5};
      nvec++;
      if (tick !== et || sq !== es ||
          div_pending !== ((j < 5) ? 4'b0010 : 4'b0000)) begin
        nerr++;
        $display("FAIL zero_div j=%0d tick=%b sq=%b pend=%b exp %b %b",
                 j, tick, sq, div_pending, et, es);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      div_wr = (j == 6);
      div_sel = 3'd3;
      div_data = 8'd2;
      cyc();
    end
    div_wr = 1'b0;
    nvec++;
    if (div_pending !== 4'b1000 || sq !== 4'hF) begin
      nerr++;
      $display("FAIL rst_pre pend=%b sq=%b exp 1000 1111", div_pending, sq);
    end
    clr_n = 1'b0;
    div_wr = 1'b1;
    div_sel = 3'd1;
    div_data = 8'd1;
    cyc();
    clr_n = 1'b1;
    div_wr = 1'b0;
    nvec++;
    if (div_pending !== 4'h0 || tick !== 4'h0 || sq !== 4'h0) begin
      nerr++;
      $display("FAIL rst_mid pend=%b tick=%b sq=%b exp all 0",
               div_pending, tick, sq);
    end
    for (int j = 1; j <= 10; j++) begin
      cyc();
      nvec++;
      if (tick !== ((j % 5 == 0) ? 4'hF : 4'h0) || div_pending !== 4'h0) begin
        nerr++;
        $display("FAIL rst_after j=%0d tick=%b pend=%b", j, tick, div_pending);
      end
    end
  endtask

  initial begin
    clr_n = 1'b0;
    run = 1'b0;
    sync = 1'b0;
    div_wr = 1'b0;
    div_sel = '0;
    div_data = '0;
    test_reset();
    test_count();
    test_div_write();
    test_pause();
    test_sync();
    test_wr_at_tc();
    test_zero_div();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
